// File: rtl/traceback_sched_if.sv
// traceback_sched_if
//   Compact-CIGAR output stream from the traceback scheduler.
//   Signals:
//     cig_valid  source -> sink   beat available
//     cig_ready  sink   -> source beat accepted
//     cig_op     source -> sink   00 match, 01 ins, 10 del, 11 terminator
//     cig_last   source -> sink   final beat of the tile
//     cig_err    source -> sink   tile aborted by timeout (only on the last beat)
//     cig_id     source -> sink   lane that owns the tile
//   Modports: master = scheduler side, slave = consumer side.
interface traceback_sched_if #(
    parameter int LOG_NUM_REQ = 1
);
    logic                   cig_valid;
    logic                   cig_ready;
    logic [1:0]             cig_op;
    logic                   cig_last;
    logic                   cig_err;
    logic [LOG_NUM_REQ-1:0] cig_id;

    modport master (
        output cig_valid, cig_op, cig_last, cig_err, cig_id,
        input  cig_ready
    );

    modport slave (
        input  cig_valid, cig_op, cig_last, cig_err, cig_id,
        output cig_ready
    );
endinterface

// File: rtl/traceback_sched.sv
// traceback_sched
//   Shares one traceback engine among NUM_REQ aligner lanes. A round-robin
//   arbiter grants one pending lane, the engine is launched with that lane's
//   start point, its run time is bounded by a timeout, and the compact CIGAR
//   it wrote is streamed out newest entry first (forward order).
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     req_valid / req_ready            per-lane request, one-hot grant pulse
//     req_score / req_diag / req_tb_state  packed per-lane start point
//     tb_rst, start_traceback          engine reset (sync, active-high) and start level
//     start_score/start_diag/tb_state  latched start point of the granted lane
//     stop_traceback, num_compact      engine done flag and number of entries written
//     cig_rd_idx / cig_rd_data         zero-latency read port into the compact CIGAR
//     cig                              output stream (traceback_sched_if.master)
//     busy                             scheduler not idle
//
//   state  | meaning
//   IDLE   | engine held in reset, arbitrating among requesting lanes
//   LAUNCH | release engine reset, raise start, clear timer
//   RUN    | engine tracing back; wait for stop or timeout
//   DRAIN  | stream compact CIGAR from index n-1 down to 0
//   ERR    | timeout: single terminator beat flagged as error
//   DONE   | engine back into reset, advance round-robin pointer
module traceback_sched #(
    parameter int NUM_REQ               = 2,
    parameter int LOG_NUM_REQ           = 1,
    parameter int LOG_MAX_WAVEFRONT_LEN = 8,
    parameter int TIMEOUT_CYCLES        = 4096,
    parameter int LOG_TIMEOUT           = 12
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ*LOG_MAX_WAVEFRONT_LEN-1:0] req_score,
    input  logic [NUM_REQ*LOG_MAX_WAVEFRONT_LEN-1:0] req_diag,
    input  logic [NUM_REQ*2-1:0]                     req_tb_state,
    output logic                                     tb_rst,
    output logic                                     start_traceback,
    output logic [LOG_MAX_WAVEFRONT_LEN-1:0]         start_score,
    output logic [LOG_MAX_WAVEFRONT_LEN-1:0]         start_diag,
    output logic [1:0]                               tb_state,
    input  logic                                     stop_traceback,
    input  logic [LOG_MAX_WAVEFRONT_LEN-1:0]         num_compact,
    output logic [LOG_MAX_WAVEFRONT_LEN-1:0]         cig_rd_idx,
    input  logic [1:0]                               cig_rd_data,
    traceback_sched_if.master                        cig,
    output logic                                     busy
);

    localparam int L = LOG_MAX_WAVEFRONT_LEN;
    localparam logic [LOG_TIMEOUT-1:0] TIMER_LAST = LOG_TIMEOUT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        ERR    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                 state, state_next;
    logic [LOG_NUM_REQ-1:0] rr_ptr;
    logic [LOG_NUM_REQ-1:0] cig_id_q;
    logic [LOG_TIMEOUT-1:0] timer;
    logic                   empty;

    logic                   grant_any;
    logic [LOG_NUM_REQ-1:0] grant_idx;
    logic [LOG_NUM_REQ-1:0] cand;
    logic [L-1:0]           sel_score;
    logic [L-1:0]           sel_diag;
    logic [1:0]             sel_state;

    logic                   cig_valid;
    logic [1:0]             cig_op;
    logic                   cig_last;
    logic                   cig_err;

    // Round-robin: scan rr_ptr+1, rr_ptr+2, ... so the lane served last has lowest priority.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = LOG_NUM_REQ'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_score = '0;
        sel_diag  = '0;
        sel_state = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == LOG_NUM_REQ'(i)) begin
                sel_score = req_score[i*L +: L];
                sel_diag  = req_diag[i*L +: L];
                sel_state = req_tb_state[i*2 +: 2];
            end
            // Gated by rst_n so no lane sees a grant while the block is held in reset.
            req_ready[i] = rst_n && (state == IDLE) && grant_any && (grant_idx == LOG_NUM_REQ'(i));
        end
    end

    always_comb begin
        state_next      = state;
        tb_rst          = 1'b1;
        start_traceback = 1'b0;
        cig_valid       = 1'b0;
        cig_op          = 2'b00;
        cig_last        = 1'b0;
        cig_err         = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) state_next = LAUNCH;
            end
            LAUNCH: begin
                tb_rst          = 1'b0;
                start_traceback = 1'b1;
                state_next      = RUN;
            end
            RUN: begin
                tb_rst          = 1'b0;
                start_traceback = 1'b1;
                if (stop_traceback)           state_next = DRAIN;
                else if (timer == TIMER_LAST) state_next = ERR;
            end
            DRAIN: begin
                // Engine kept out of reset so its compact CIGAR array stays readable.
                tb_rst          = 1'b0;
                start_traceback = 1'b1;
                cig_valid       = 1'b1;
                cig_op          = empty ? 2'b11 : cig_rd_data;
                cig_last        = empty || (cig_rd_idx == '0);
                if (cig.cig_ready && cig_last) state_next = DONE;
            end
            ERR: begin
                // Aborted run: engine goes back into reset immediately.
                cig_valid = 1'b1;
                cig_op    = 2'b11;
                cig_last  = 1'b1;
                cig_err   = 1'b1;
                if (cig.cig_ready) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= LOG_NUM_REQ'(NUM_REQ - 1);
            cig_id_q    <= '0;
            start_score <= '0;
            start_diag  <= '0;
            tb_state    <= '0;
            timer       <= '0;
            empty       <= 1'b0;
            cig_rd_idx  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        start_score <= sel_score;
                        start_diag  <= sel_diag;
                        tb_state    <= sel_state;
                        cig_id_q    <= grant_idx;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                end
                RUN: begin
                    // Saturate: RUN exits on the terminal count, so the timer never wraps.
                    if (timer != TIMER_LAST) timer <= timer + 1'b1;
                    if (stop_traceback) begin
                        empty      <= (num_compact == '0);
                        cig_rd_idx <= (num_compact == '0) ? '0 : num_compact - 1'b1;
                    end
                end
                DRAIN: begin
                    if (cig.cig_ready && !cig_last) cig_rd_idx <= cig_rd_idx - 1'b1;
                end
                DONE: begin
                    rr_ptr <= cig_id_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign cig.cig_valid = cig_valid;
    assign cig.cig_op    = cig_op;
    assign cig.cig_last  = cig_last;
    assign cig.cig_err   = cig_err;
    assign cig.cig_id    = cig_id_q;
    assign busy          = (state != IDLE);

endmodule
